// File: rtl/one_unit_pkg.sv
// rtl/one_unit_pkg.sv - shared state encodings and default constants for the ICA iteration unit
//
// Contents:
//   ica_state_t  - 3-bit controller state encoding (one_unit_iter_controller)
//   fast_state_t - 3-bit fast-iteration sequencer encoding (the controller only sees its busy flag)
//   DEF_*        - default parameter values for the controller
//   sat_inc8     - 8-bit saturating increment
package one_unit_pkg;

  typedef enum logic [2:0] {
    ICA_IDLE   = 3'd0,
    ICA_LAUNCH = 3'd1,
    ICA_RUN    = 3'd2,
    ICA_NORM   = 3'd3,
    ICA_CONV   = 3'd4,
    ICA_DONE   = 3'd5,
    ICA_ERR    = 3'd6
  } ica_state_t;

  // Fast sequencer phases: 4 MUL + 127 MEAN + 1 MUL5 busy cycles, then SUB with busy low.
  typedef enum logic [2:0] {
    FAST_IDLE = 3'd0,
    FAST_MUL  = 3'd1,
    FAST_MEAN = 3'd2,
    FAST_MUL5 = 3'd3,
    FAST_SUB  = 3'd4
  } fast_state_t;

  localparam logic [7:0] DEF_MAX_ITER     = 8'd16;
  localparam logic [3:0] DEF_NORM_CYCLES  = 4'd4;
  localparam logic [3:0] DEF_RISE_TIMEOUT = 4'd4;
  localparam logic [8:0] DEF_BUSY_MAX     = 9'd256;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/iter_timer.sv
// rtl/iter_timer.sv - 9-bit up-counter with clear and last-cycle flag
//
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   clear      - synchronous clear to zero (wins over en)
//   en         - count enable (saturates at all-ones)
//   limit      - number of cycles in the current window
//   count      - cycles already elapsed in the window
//   last       - high during the limit-th cycle of the window (count == limit-1)
module iter_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       en,
  input  logic [8:0] limit,
  output logic [8:0] count,
  output logic       last
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 9'd0;
    end else if (clear) begin
      count <= 9'd0;
    end else if (en && (count != 9'h1FF)) begin
      count <= count + 9'd1;
    end
  end

  assign last = (count == (limit - 9'd1));

endmodule

// File: rtl/one_unit_iter_controller.sv
// rtl/one_unit_iter_controller.sv - iteration controller around the fast ICA sequencer
//
// Ports:
//   clk_fast  - clock, rising edge
//   go_ica    - asynchronous active-low reset
//   start     - begin a run (sampled in IDLE/DONE/ERR only)
//   fast_busy - busy flag from the fast-iteration sequencer
//   converged - convergence verdict, read while en_conv=1
//   go_fast   - registered release for the fast sequencer (1 in LAUNCH and RUN)
//   en_norm   - normalise enable, NORM_CYCLES cycles per iteration
//   en_conv   - one-cycle convergence sample strobe
//   w_update  - one-cycle weight latch pulse, first NORM cycle
//   ica_busy, ica_done, ica_conv, ica_err - status flags
//   iter_cnt  - completed iterations in the current run
module one_unit_iter_controller
  import one_unit_pkg::*;
#(
  parameter logic [7:0] MAX_ITER     = DEF_MAX_ITER,
  parameter logic [3:0] NORM_CYCLES  = DEF_NORM_CYCLES,
  parameter logic [3:0] RISE_TIMEOUT = DEF_RISE_TIMEOUT,
  parameter logic [8:0] BUSY_MAX     = DEF_BUSY_MAX
) (
  input  logic       clk_fast,
  input  logic       go_ica,
  input  logic       start,
  input  logic       fast_busy,
  input  logic       converged,
  output logic       go_fast,
  output logic       en_norm,
  output logic       en_conv,
  output logic       w_update,
  output logic       ica_busy,
  output logic       ica_done,
  output logic       ica_conv,
  output logic       ica_err,
  output logic [7:0] iter_cnt
);

  ica_state_t state, state_next;

  logic [8:0] timer_count;
  logic [8:0] timer_limit;
  logic       timer_last;
  logic       timer_clear;
  logic       timer_en;

  logic       iter_max_hit;
  logic       launch_req;
  logic       go_fast_q;
  logic       ica_conv_q;
  logic [7:0] iter_cnt_q;

  always_ff @(posedge clk_fast or negedge go_ica) begin
    if (!go_ica) begin
      state <= ICA_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Widened so MAX_ITER = 8'hFF is still reachable without wrap.
  assign iter_max_hit = (({1'b0, iter_cnt_q} + 9'd1) == {1'b0, MAX_ITER});

  always_comb begin
    state_next = state;
    case (state)
      ICA_IDLE, ICA_DONE, ICA_ERR: begin
        if (start) state_next = ICA_LAUNCH;
      end
      ICA_LAUNCH: begin
        if (fast_busy)       state_next = ICA_RUN;
        else if (timer_last) state_next = ICA_ERR;
      end
      ICA_RUN: begin
        // The cycle busy drops is the sequencer's SUB cycle.
        if (!fast_busy)      state_next = ICA_NORM;
        else if (timer_last) state_next = ICA_ERR;
      end
      ICA_NORM: begin
        if (timer_last) state_next = ICA_NORM == state ? ICA_CONV : state;
      end
      ICA_CONV: begin
        // Convergence wins over the iteration limit for the ica_conv verdict.
        if (converged || iter_max_hit) state_next = ICA_DONE;
        else                           state_next = ICA_LAUNCH;
      end
      default: state_next = ICA_IDLE;
    endcase
  end

  always_comb begin
    timer_limit = BUSY_MAX;
    case (state)
      ICA_LAUNCH: timer_limit = {5'd0, RISE_TIMEOUT};
      ICA_NORM:   timer_limit = {5'd0, NORM_CYCLES};
      default:    timer_limit = BUSY_MAX;
    endcase
  end

  // One shared timer: every state change restarts the window.
  assign timer_clear = (state_next != state);
  assign timer_en    = (state == ICA_LAUNCH) || (state == ICA_RUN) || (state == ICA_NORM);

  iter_timer u_timer (
    .clk   (clk_fast),
    .rst_n (go_ica),
    .clear (timer_clear),
    .en    (timer_en),
    .limit (timer_limit),
    .count (timer_count),
    .last  (timer_last)
  );

  assign launch_req = (state_next == ICA_LAUNCH) &&
                      ((state == ICA_IDLE) || (state == ICA_DONE) || (state == ICA_ERR));

  always_ff @(posedge clk_fast or negedge go_ica) begin
    if (!go_ica) begin
      go_fast_q  <= 1'b0;
      iter_cnt_q <= 8'd0;
      ica_conv_q <= 1'b0;
    end else begin
      // Decoded from next state so the release is a clean flop output.
      go_fast_q <= (state_next == ICA_LAUNCH) || (state_next == ICA_RUN);
      if (launch_req) begin
        iter_cnt_q <= 8'd0;
        ica_conv_q <= 1'b0;
      end else if (state == ICA_CONV) begin
        iter_cnt_q <= sat_inc8(iter_cnt_q);
        if (converged) ica_conv_q <= 1'b1;
      end
    end
  end

  assign go_fast  = go_fast_q;
  assign iter_cnt = iter_cnt_q;
  assign ica_conv = ica_conv_q;
  assign en_norm  = (state == ICA_NORM);
  assign en_conv  = (state == ICA_CONV);
  assign w_update = (state == ICA_NORM) && (timer_count == 9'd0);
  assign ica_busy = (state == ICA_LAUNCH) || (state == ICA_RUN) ||
                    (state == ICA_NORM)   || (state == ICA_CONV);
  assign ica_done = (state == ICA_DONE);
  assign ica_err  = (state == ICA_ERR);

endmodule

// File: tb/tb_one_unit_iter_controller.sv
// tb/tb_one_unit_iter_controller.sv - directed self-checking bench for one_unit_iter_controller
module tb_one_unit_iter_controller;

  logic       clk_fast = 1'b0;
  logic       go_ica;
  logic       start;
  logic       fast_busy;
  logic       converged;
  logic       go_fast;
  logic       en_norm;
  logic       en_conv;
  logic       w_update;
  logic       ica_busy;
  logic       ica_done;
  logic       ica_conv;
  logic       ica_err;
  logic [7:0] iter_cnt;

  always #5 clk_fast = ~clk_fast;

  one_unit_iter_controller #(.MAX_ITER(8'd4)) dut (
    .clk_fast  (clk_fast),
    .go_ica    (go_ica),
    .start     (start),
    .fast_busy (fast_busy),
    .converged (converged),
    .go_fast   (go_fast),
    .en_norm   (en_norm),
    .en_conv   (en_conv),
    .w_update  (w_update),
    .ica_busy  (ica_busy),
    .ica_done  (ica_done),
    .ica_conv  (ica_conv),
    .ica_err   (ica_err),
    .iter_cnt  (iter_cnt)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // Environment: 0 = sequencer model, 1 = busy stuck 0, 2 = busy stuck 1,
  // 3 = sequencer model plus busy glitch during NORM/CONV.
  int         mode        = 0;
  int         conv_target = 0;
  int         wupd_base   = 0;
  logic [7:0] seq_cnt     = 8'd0;
  logic       seq_busy;

  int   cyc       = 0;
  int   launches  = 0;
  int   wupd      = 0;
  int   norm_cyc  = 0;
  int   last_w    = 0;
  int   prev_w    = 0;
  logic prev_gf   = 1'b0;

  // Sequencer model: busy for 132 cycles starting one edge after go_fast rises.
  always @(posedge clk_fast) begin
    cyc <= cyc + 1;
    if (!go_fast)              seq_cnt <= 8'd0;
    else if (seq_cnt != 8'hFF) seq_cnt <= seq_cnt + 8'd1;
  end

  assign seq_busy  = (seq_cnt >= 8'd1) && (seq_cnt <= 8'd132);
  assign converged = (conv_target != 0) && ((wupd - wupd_base) == conv_target);

  always_comb begin
    case (mode)
      1:       fast_busy = 1'b0;
      2:       fast_busy = 1'b1;
      3:       fast_busy = seq_busy | en_norm | en_conv;
      default: fast_busy = seq_busy;
    endcase
  end

  always @(negedge clk_fast) begin
    prev_gf <= go_fast;
    if (go_fast && !prev_gf) launches <= launches + 1;
    if (w_update) begin
      wupd   <= wupd + 1;
      prev_w <= last_w;
      last_w <= cyc;
    end
    if (en_norm) norm_cyc <= norm_cyc + 1;
  end

  task automatic check(input string tag, input int obs, input int exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk_fast);
    #1;
  endtask

  task automatic wait_end(input string tag, input int budget);
    int n = 0;
    while (!(ica_done || ica_err) && n < budget) begin
      step();
      n++;
    end
    check({tag, "_end_seen"}, int'(ica_done | ica_err), 1);
  endtask

  initial begin
    int k;
    int base_launch;
    int base_norm;

    go_ica = 1'b0;
    start  = 1'b0;
    repeat (3) step();
    check("rst_outputs", int'({go_fast, en_norm, en_conv, w_update,
                               ica_busy, ica_done, ica_conv, ica_err}), 0);
    check("rst_iter_cnt", int'(iter_cnt), 0);
    go_ica = 1'b1;
    step();
    check("idle_no_start_busy", int'(ica_busy), 0);

    // Converge on the third iteration.
    conv_target = 3; wupd_base = wupd; base_launch = launches; base_norm = norm_cyc; mode = 0;
    start = 1'b1;
    step();
    check("t1_launch_go_fast", int'(go_fast), 1);
    check("t1_launch_busy", int'(ica_busy), 1);
    start = 1'b0;
    wait_end("t1", 2000);
    check("t1_iter_cnt", int'(iter_cnt), 3);
    check("t1_done", int'(ica_done), 1);
    check("t1_conv", int'(ica_conv), 1);
    check("t1_go_fast", int'(go_fast), 0);
    check("t1_busy", int'(ica_busy), 0);
    check("t1_w_updates", wupd - wupd_base, 3);
    check("t1_launches", launches - base_launch, 3);
    check("t1_norm_cycles", norm_cyc - base_norm, 12);
    check("t1_iter_period", last_w - prev_w, 139);

    // Never converges: MAX_ITER=4 ends the run.
    conv_target = 0; base_launch = launches;
    start = 1'b1;
    step();
    check("t2_relaunch_iter_cnt", int'(iter_cnt), 0);
    check("t2_relaunch_done", int'(ica_done), 0);
    check("t2_relaunch_conv", int'(ica_conv), 0);
    start = 1'b0;
    wait_end("t2", 2000);
    check("t2_launches", launches - base_launch, 4);
    check("t2_iter_cnt", int'(iter_cnt), 4);
    check("t2_done", int'(ica_done), 1);
    check("t2_conv", int'(ica_conv), 0);
    repeat (3) step();
    check("t2_done_hold", int'(ica_done), 1);

    // fast_busy never rises: error after 4 LAUNCH cycles.
    mode = 1; start = 1'b1; k = 0;
    do begin
      step();
      k++;
      start = 1'b0;
    end while (!ica_err && k < 20);
    check("t3_rise_timeout_cycles", k, 5);
    check("t3_err", int'(ica_err), 1);
    check("t3_go_fast", int'(go_fast), 0);
    check("t3_busy", int'(ica_busy), 0);
    mode = 3; conv_target = 1; wupd_base = wupd; base_norm = norm_cyc;
    start = 1'b1;
    step();
    start = 1'b0;
    check("t3_restart_err", int'(ica_err), 0);
    check("t3_restart_go_fast", int'(go_fast), 1);
    wait_end("t3", 1000);
    check("t3_glitch_done", int'(ica_done), 1);
    check("t3_glitch_conv", int'(ica_conv), 1);
    check("t3_glitch_iter_cnt", int'(iter_cnt), 1);
    check("t3_glitch_norm_cycles", norm_cyc - base_norm, 4);

    // fast_busy stuck high: error after 256 RUN cycles.
    mode = 2; start = 1'b1; k = 0;
    do begin
      step();
      k++;
      start = 1'b0;
    end while (!ica_err && k < 400);
    check("t4_busy_timeout_cycles", k, 258);
    check("t4_err", int'(ica_err), 1);
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (50) step();
    check("t4_midrun_go_fast", int'(go_fast), 1);
    go_ica = 1'b0;
    #1;
    check("t4_async_reset_outputs", int'({go_fast, en_norm, en_conv, w_update,
                                          ica_busy, ica_done, ica_conv, ica_err}), 0);
    check("t4_async_reset_iter_cnt", int'(iter_cnt), 0);
    step();
    go_ica = 1'b1; mode = 0;
    repeat (3) step();
    check("t4_idle_after_reset", int'(go_fast | ica_busy), 0);
    start = 1'b1;
    step();
    check("t4_first_launch", int'(go_fast), 1);
    start = 1'b0;
    step();
    go_ica = 1'b0;
    step();
    go_ica = 1'b1;
    step();

    // start held high; converged on the last allowed iteration.
    conv_target = 4; wupd_base = wupd; base_launch = launches; mode = 0;
    start = 1'b1;
    wait_end("t5", 3000);
    check("t5_launches", launches - base_launch, 4);
    check("t5_iter_cnt", int'(iter_cnt), 4);
    check("t5_conv", int'(ica_conv), 1);
    check("t5_done", int'(ica_done), 1);
    step();
    check("t5_restart_go_fast", int'(go_fast), 1);
    check("t5_restart_done", int'(ica_done), 0);
    check("t5_restart_conv", int'(ica_conv), 0);
    check("t5_restart_iter_cnt", int'(iter_cnt), 0);
    start  = 1'b0;
    go_ica = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
